// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the HI/LO register pair.
// Runs MULT/MULTU/DIV/DIVU one radix-2 step per cycle on operand magnitudes.
// Signs are restored in the last step, so a result takes WIDTH cycles after the
// start edge. MTHI/MTLO-style direct writes are accepted only while idle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             is_div_q;
  // neg_lo_q negates the product (mul) or the quotient (div);
  // neg_hi_q negates the remainder (div only).
  logic             neg_lo_q;
  logic             neg_hi_q;
  // acc_hi_q/acc_lo_q: partial product or remainder/quotient shift pair.
  // opb_q: multiplicand magnitude (mul) or divisor magnitude (div).
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opb_q;

  // Operand decode at the start edge
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  // Decode the requested operation into magnitudes and sign flags
  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    // The most negative value maps onto itself, which reads correctly as unsigned.
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    b_zero    = (b == '0);
  end

  // One radix-2 step plus the sign correction used on the final step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  // Compute the next shift-add / restoring-divide step and the signed result
  always_comb begin
    // Shift-add: multiplier bits are consumed from the bottom of acc_lo_q while
    // product bits shift in from the top.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Restoring divide: remainder < divisor keeps the trial difference within
    // WIDTH+1 bits, so its top bit is a clean borrow indicator.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[WIDTH];
    div_hi    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {acc_lo_q[WIDTH-2:0], div_ok};

    step_hi   = is_div_q ? div_hi : mul_hi;
    step_lo   = is_div_q ? div_lo : mul_lo;

    prod      = {step_hi, step_lo};
    prod_neg  = ~prod + 1'b1;

    if (is_div_q) begin
      fin_hi = neg_hi_q ? (~step_hi + 1'b1) : step_hi;
      fin_lo = neg_lo_q ? (~step_lo + 1'b1) : step_lo;
    end else begin
      fin_hi = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : step_hi;
      fin_lo = neg_lo_q ? prod_neg[WIDTH-1:0] : step_lo;
    end
  end

  // Control FSM, iteration datapath and the HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opb_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (hi_we) begin
            hi <= wdata;
          end
          if (lo_we) begin
            lo <= wdata;
          end
          if (start) begin
            div_by_zero <= 1'b0;
            if (op_div && b_zero) begin
              // Division by zero completes at once and leaves HI/LO alone.
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state_q  <= StRun;
              busy     <= 1'b1;
              cnt_q    <= '0;
              is_div_q <= op_div;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= a_neg;
              acc_hi_q <= '0;
              acc_lo_q <= op_div ? a_mag : b_mag;
              opb_q    <= op_div ? b_mag : a_mag;
            end
          end
        end
        StRun: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            hi      <= fin_hi;
            lo      <= fin_lo;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance, each shadowed by a
// transaction-level model (plain integer arithmetic plus a latency countdown)
// compared on every cycle, plus literal expectations from hand calculation.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, st32, hwe32, lwe32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;

  logic        rst8, st8, hwe8, lwe8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .start(st32), .op(op32), .a(a32), .b(b32),
    .hi_we(hwe32), .lo_we(lwe32), .wdata(wd32), .busy(busy32), .done(done32),
    .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(st8), .op(op8), .a(a8), .b(b8),
    .hi_we(hwe8), .lo_we(lwe8), .wdata(wd8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    longint unsigned hi, lo, phi, plo;
    bit busy, done, dbz;
    int rem;
  } mdl_t;

  // Architectural result of one operation at width w, by plain integer arithmetic
  function automatic void calc(input int w, input bit [1:0] op, input longint unsigned a,
                               input longint unsigned b, output longint unsigned h,
                               output longint unsigned l);
    longint unsigned mask = (64'd1 << w) - 1;
    longint sa = longint'(a << (64 - w)) >>> (64 - w);
    longint sb = longint'(b << (64 - w)) >>> (64 - w);
    longint unsigned pu;
    case (op)
      2'd0: begin pu = longint'(sa * sb); h = (pu >> w) & mask; l = pu & mask; end
      2'd1: begin pu = a * b; h = (pu >> w) & mask; l = pu & mask; end
      2'd2: begin l = longint'(sa / sb) & mask; h = longint'(sa % sb) & mask; end
      default: begin l = (a / b) & mask; h = (a % b) & mask; end
    endcase
  endfunction

  // One clock edge of the unit's observable behaviour
  function automatic mdl_t mstep(input mdl_t m, input int w, input bit rst, input bit st,
                                 input bit [1:0] op, input longint unsigned a,
                                 input longint unsigned b, input longint unsigned wd,
                                 input bit hwe, input bit lwe);
    mdl_t n = m;
    if (rst) begin
      n.hi = 0; n.lo = 0; n.phi = 0; n.plo = 0;
      n.busy = 0; n.done = 0; n.dbz = 0; n.rem = 0;
      return n;
    end
    n.done = 0;
    if (!m.busy) begin
      if (hwe) n.hi = wd;
      if (lwe) n.lo = wd;
      if (st) begin
        n.dbz = 0;
        if (op[1] && b == 0) begin
          n.dbz = 1;
          n.done = 1;
        end else begin
          calc(w, op, a, b, n.phi, n.plo);
          n.busy = 1;
          n.rem = w;
        end
      end
    end else begin
      n.rem--;
      if (n.rem == 0) begin
        n.hi = n.phi; n.lo = n.plo; n.busy = 0; n.done = 1;
      end
    end
    return n;
  endfunction

  mdl_t m32, m8;

  // Advance both models with the DUTs, then compare every output
  always @(posedge clk) begin
    m32 = mstep(m32, 32, rst32, st32, op32, 64'(a32), 64'(b32), 64'(wd32), hwe32, lwe32);
    m8  = mstep(m8, 8, rst8, st8, op8, 64'(a8), 64'(b8), 64'(wd8), hwe8, lwe8);
    #1;
    chk("busy32", 64'(busy32), 64'(m32.busy));
    chk("done32", 64'(done32), 64'(m32.done));
    chk("dbz32", 64'(dbz32), 64'(m32.dbz));
    chk("hi32", 64'(hi32), m32.hi);
    chk("lo32", 64'(lo32), m32.lo);
    chk("busy8", 64'(busy8), 64'(m8.busy));
    chk("done8", 64'(done8), 64'(m8.done));
    chk("dbz8", 64'(dbz8), 64'(m8.dbz));
    chk("hi8", 64'(hi8), m8.hi);
    chk("lo8", 64'(lo8), m8.lo);
  end

  task automatic wait_done32(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32) break;
      if (busy32) nbusy++;
      @(negedge clk);
    end
    chk("done32_seen", 64'(done32), 64'd1);
  endtask

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy);
    @(negedge clk);
    st32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(negedge clk);
    st32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    wait_done32(nbusy);
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int nbusy);
    @(negedge clk);
    st8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    st8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) break;
      if (busy8) nbusy++;
      @(negedge clk);
    end
    chk("done8_seen", 64'(done8), 64'd1);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'($urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int nb;
    int nd;
    rst32 = 1'b1; st32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0;
    hwe32 = 1'b0; lwe32 = 1'b0; wd32 = '0;
    rst8 = 1'b1; st8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0;
    hwe8 = 1'b0; lwe8 = 1'b0; wd8 = '0;
    repeat (2) @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;
    chk("reset_hi", 64'(hi32), 64'h0);
    chk("reset_lo", 64'(lo32), 64'h0);
    chk("reset_busy", 64'(busy32), 64'h0);

    // Unsigned full-range product and latency
    run32(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
    chk("multu_busy_cycles", 64'(nb), 64'd32);
    chk("multu_hi", 64'(hi32), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo32), 64'h0000_0001);
    @(negedge clk);
    chk("multu_done_once", 64'(done32), 64'h0);

    // Signed multiply and signed/unsigned divide
    run32(2'd0, 32'hFFFF_FFFD, 32'd7, nb);
    chk("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo32), 64'hFFFF_FFEB);
    run32(2'd2, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_lo", 64'(lo32), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi32), 64'hFFFF_FFFF);
    run32(2'd3, 32'd7, 32'd2, nb);
    chk("divu_lo", 64'(lo32), 64'd3);
    chk("divu_hi", 64'(hi32), 64'd1);

    // Overflow divide, then divide by zero
    run32(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("divovf_lo", 64'(lo32), 64'h8000_0000);
    chk("divovf_hi", 64'(hi32), 64'h0);
    chk("divovf_dbz", 64'(dbz32), 64'h0);
    run32(2'd3, 32'd5, 32'd0, nb);
    chk("dbz_busy_cycles", 64'(nb), 64'd0);
    chk("dbz_flag", 64'(dbz32), 64'h1);
    chk("dbz_hi", 64'(hi32), 64'h0);
    chk("dbz_lo", 64'(lo32), 64'h8000_0000);

    // Start and HI write while busy are ignored; LO write in idle lands
    @(negedge clk);
    st32 = 1'b1; op32 = 2'd0; a32 = 32'd3; b32 = 32'd4;
    @(negedge clk);
    st32 = 1'b0;
    repeat (3) @(negedge clk);
    st32 = 1'b1; op32 = 2'd3; a32 = 32'd99; b32 = 32'd5; hwe32 = 1'b1; wd32 = 32'hDEAD;
    @(negedge clk);
    st32 = 1'b0; hwe32 = 1'b0;
    wait_done32(nb);
    chk("busy_ignore_hi", 64'(hi32), 64'h0);
    chk("busy_ignore_lo", 64'(lo32), 64'd12);
    @(negedge clk);
    lwe32 = 1'b1; wd32 = 32'h1234;
    @(negedge clk);
    lwe32 = 1'b0;
    chk("mtlo_lo", 64'(lo32), 64'h1234);
    chk("mtlo_hi", 64'(hi32), 64'h0);

    // Reset mid-operation aborts it
    @(negedge clk);
    st32 = 1'b1; op32 = 2'd3; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    st32 = 1'b0;
    repeat (8) @(negedge clk);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    chk("abort_hi", 64'(hi32), 64'h0);
    chk("abort_lo", 64'(lo32), 64'h0);
    chk("abort_busy", 64'(busy32), 64'h0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run32(2'd1, 32'd6, 32'd7, nb);
    chk("after_abort_lo", 64'(lo32), 64'd42);

    // Narrow instance
    run8(2'd0, 8'h80, 8'h80, nb);
    chk("w8_busy_cycles", 64'(nb), 64'd8);
    chk("w8_mult_hi", 64'(hi8), 64'h40);
    chk("w8_mult_lo", 64'(lo8), 64'h00);
    run8(2'd2, 8'h81, 8'h10, nb);
    chk("w8_div_lo", 64'(lo8), 64'hF9);
    chk("w8_div_hi", 64'(hi8), 64'hF1);

    // Random traffic on both instances, checked by the models every cycle
    repeat (3000) begin
      @(negedge clk);
      rst32 = ($urandom_range(0, 299) == 0);
      st32  = ($urandom_range(0, 1) == 0);
      op32  = 2'($urandom);
      a32   = pick32();
      b32   = pick32();
      hwe32 = ($urandom_range(0, 9) == 0);
      lwe32 = ($urandom_range(0, 9) == 0);
      wd32  = $urandom;
      rst8  = ($urandom_range(0, 199) == 0);
      st8   = ($urandom_range(0, 1) == 0);
      op8   = 2'($urandom);
      a8    = pick8();
      b8    = pick8();
      hwe8  = ($urandom_range(0, 9) == 0);
      lwe8  = ($urandom_range(0, 9) == 0);
      wd8   = 8'($urandom);
    end
    @(negedge clk);
    rst32 = 1'b0; st32 = 1'b0; hwe32 = 1'b0; lwe32 = 1'b0;
    rst8 = 1'b0; st8 = 1'b0; hwe8 = 1'b0; lwe8 = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit holding the HI/LO register pair for the MIPS datapath. It sits beside the combinational ALU in the execute stage and executes MULT, MULTU, DIV and DIVU over multiple cycles. While it runs, busy stalls the pipeline. It also provides direct HI/LO writes for MTHI/MTLO and continuous HI/LO read-out for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be >= 4)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request an operation; sampled only when busy=0
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a  input  WIDTH  operand rs (multiplicand / dividend)
b  input  WIDTH  operand rt (multiplier / divisor)
hi_we  input  1  write wdata into HI (MTHI)
lo_we  input  1  write wdata into LO (MTLO)
wdata  input  WIDTH  data for hi_we/lo_we
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by an operation
div_by_zero  output  1  sticky flag for the last operation; set when a DIV/DIVU had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, takes priority over everything): hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0. Reset asserted mid-operation aborts the operation; no partial result reaches HI/LO.
- Two states: IDLE and RUN.
- IDLE, start=1 at edge E0:
  - latch op, |a|, |b| and the sign info;
  - clear div_by_zero;
  - busy=1 after E0.
- Exception: DIV/DIVU with b==0:
  - no RUN; at E0 div_by_zero=1, done=1 for one cycle, busy stays 0;
  - hi/lo unchanged.
- RUN:
  - one radix-2 step per edge (shift-add multiply, restoring divide on magnitudes);
  - counter runs WIDTH steps, edges E1..E_WIDTH;
  - at E_WIDTH: HI/LO written, busy=0, done=1 for exactly the following cycle;
  - result latency is WIDTH cycles from the start edge;
  - back-to-back: start may be asserted in the done cycle and is accepted.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero. Signed remainder takes the dividend's sign.
  - DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1) (wraps), hi = 0, no flag.
  - Signed correction (negate product/quotient/remainder) is applied in the final step, inside the WIDTH-cycle latency.
- start while busy=1: ignored; the operation in flight continues unaffected.
- hi_we/lo_we:
  - In IDLE they write on the edge; the new value is visible the next cycle.
  - While busy=1 they are ignored.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, the write happens and the operation starts. The operation's result later overwrites both registers.
- op, a, b may change freely after the start edge; only the latched copies are used.
- Outputs are registered; hi/lo hold their values between updates.

Test Plan:
1. reset; MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 32 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV a=-7 b=2 -> lo=-3 (0xFFFFFFFD), hi=-1. DIVU a=7 b=2 -> lo=3, hi=1.
3. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0, div_by_zero=0. DIVU a=5 b=0 -> done next cycle, busy never high, div_by_zero=1, hi/lo unchanged.
4. Start MULT 3*4; at cycle 5 assert start with different operands and hi_we with wdata=0xDEAD -> both ignored; result hi=0, lo=12. Then in IDLE assert lo_we with 0x1234 -> lo=0x1234 next cycle.
5. Start DIVU 100/7; assert reset at cycle 10 -> next cycle hi=lo=0, busy=0, done never pulses. New MULTU 6*7 afterwards -> lo=42.
6. WIDTH=8 instance: MULT a=0x80 b=0x80 -> 8-cycle latency, hi=0x40, lo=0x00. DIV a=0x81 (-127) b=0x10 -> lo=0xF9 (-7), hi=0xF1 (-15).
